// File: rtl/uart_pkg.sv
// Shared UART definitions: default data width and the TX FIFO launch FSM states.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    TXF_IDLE,
    TXF_LAUNCH,
    TXF_WAIT_BUSY,
    TXF_WAIT_DONE
  } txf_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous read, contents not reset.
module uart_fifo_mem #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter through a busy-aware launch FSM.
// Define UART_TX_FIFO_OVF_EN to add the sticky ovf flag and its ovf_clr input.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = UART_DATA_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_en,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_send,
  input  logic                       tx_busy
`ifdef UART_TX_FIFO_OVF_EN
  ,
  output logic                       ovf,
  input  logic                       ovf_clr
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_nxt;
  logic [DATA_W-1:0] rd_data;
  logic              push, pop;
  txf_state_e        state, state_nxt;

  // Flush wins over a same-cycle write; a full FIFO drops writes even if a pop happens.
  assign push = wr_en && !full && !flush;

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .we      (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CW'(1);
    else if (pop && !push) count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      TXF_IDLE: begin
        if (!empty && !tx_busy && !flush) begin
          pop       = 1'b1;
          state_nxt = TXF_LAUNCH;
        end
      end
      TXF_LAUNCH:    state_nxt = TXF_WAIT_BUSY;
      TXF_WAIT_BUSY: if (tx_busy)  state_nxt = TXF_WAIT_DONE;
      TXF_WAIT_DONE: if (!tx_busy) state_nxt = TXF_IDLE;
      default:       state_nxt = TXF_IDLE;
    endcase
  end

  // tx_send is registered from the next state so it is high exactly while in LAUNCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= TXF_IDLE;
      tx_send <= 1'b0;
      tx_data <= '0;
    end else begin
      state   <= state_nxt;
      tx_send <= (state_nxt == TXF_LAUNCH);
      if (pop) tx_data <= rd_data;
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    ovf <= 1'b0;
    else if (ovf_clr)                ovf <= 1'b0;
    else if (wr_en && (full || flush)) ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo with a behavioural transmitter busy model.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CW     = $clog2(DEPTH + 1);

  logic              clk     = 1'b0;
  logic              reset_n = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_en   = 1'b0;
  logic              flush   = 1'b0;
  logic              full, empty, tx_send, tx_busy;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] tx_data;
`ifdef UART_TX_FIFO_OVF_EN
  logic              ovf;
  logic              ovf_clr = 1'b0;
`endif

  logic        tx_auto    = 1'b0;
  logic        busy_man   = 1'b0;
  logic        busy_model = 1'b0;
  int unsigned busy_len   = 6;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sent_log[$];
  int         gap_log[$];

  assign tx_busy = tx_auto ? busy_model : busy_man;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .flush   (flush),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .tx_data (tx_data),
    .tx_send (tx_send),
    .tx_busy (tx_busy)
`ifdef UART_TX_FIFO_OVF_EN
    ,
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
`endif
  );

  // Transmitter stand-in: samples send in the LAUNCH cycle, raises busy the next cycle for busy_len cycles.
  initial begin : tx_model
    int  left;
    bit  pending;
    int  cyc;
    int  fall_cyc;
    left = 0; pending = 0; cyc = 0; fall_cyc = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        busy_model = 1'b0; left = 0; pending = 0; fall_cyc = -1;
      end else begin
        if (pending) begin
          busy_model = 1'b1; left = int'(busy_len); pending = 0;
        end else if (left > 0) begin
          left--;
          if (left == 0) begin busy_model = 1'b0; fall_cyc = cyc; end
        end
        if (tx_send) begin
          sent_log.push_back(tx_data);
          if (fall_cyc >= 0) gap_log.push_back(cyc - fall_cyc);
          fall_cyc = -1;
          pending  = tx_auto;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    int n = 0;
    while (tx_busy !== lvl && n < 200) begin @(negedge clk); n++; end
    check(tag, 32'(tx_busy), 32'(lvl));
  endtask

  task automatic wait_log(input int sz, input string tag);
    int n = 0;
    while (sent_log.size() < sz && n < 3000) begin @(negedge clk); n++; end
    check(tag, 32'(sent_log.size()), 32'(sz));
  endtask

  initial begin : main
    int wr, sent, i, guard;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full",  32'(full), 0);
    check("rst_send",  32'(tx_send), 0);
    check("rst_data",  32'(tx_data), 0);
    reset_n = 1'b1;

    // Single byte, busy held low: send at cycle 2, then FSM parks in WAIT_BUSY
    @(negedge clk);
    wr_data = 8'hA5; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    check("single_c1_count", 32'(count), 1);
    check("single_c1_empty", 32'(empty), 0);
    check("single_c1_send",  32'(tx_send), 0);
    @(negedge clk);
    check("single_c2_send",  32'(tx_send), 1);
    check("single_c2_data",  32'(tx_data), 32'h A5);
    check("single_c2_count", 32'(count), 0);
    check("single_c2_empty", 32'(empty), 1);
    repeat (3) begin
      @(negedge clk);
      check("single_hold_send", 32'(tx_send), 0);
    end
    check("single_hold_data", 32'(tx_data), 32'h A5);
    busy_man = 1'b1;
    @(negedge clk);
    busy_man = 1'b0;
    @(negedge clk);

    // Fill to DEPTH with busy high so nothing pops
    busy_man = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      wr_data = 8'(k); wr_en = 1'b1;
      @(negedge clk);
      if (k == 15) begin
        check("fill15_count", 32'(count), 15);
        check("fill15_full",  32'(full), 0);
      end
    end
    wr_en = 1'b0;
    check("fill_count", 32'(count), 16);
    check("fill_full",  32'(full), 1);
    check("fill_empty", 32'(empty), 0);

    // Overflow write is dropped
    wr_data = 8'hFF; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    check("ovf_count", 32'(count), 16);
    check("ovf_full",  32'(full), 1);
`ifdef UART_TX_FIFO_OVF_EN
    check("ovf_set", 32'(ovf), 1);
    @(negedge clk);
    check("ovf_sticky", 32'(ovf), 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf), 0);
`endif

    // Drain through the transmitter model: order, exactly-once, 2-cycle re-launch gap
    sent_log.delete(); gap_log.delete();
    busy_len = 6;
    tx_auto  = 1'b1;
    wait_log(16, "drain_size");
    repeat (30) @(negedge clk);
    check("drain_size_final", 32'(sent_log.size()), 16);
    for (int k = 0; k < 16 && k < sent_log.size(); k++)
      check("drain_byte", 32'(sent_log[k]), 32'(k + 1));
    check("drain_gap_n", 32'(gap_log.size()), 15);
    for (int k = 0; k < gap_log.size(); k++)
      check("drain_gap", 32'(gap_log[k]), 2);
    check("drain_empty", 32'(empty), 1);

    // Wrap-around: 40 bytes, occupancy capped at 3, count checked every cycle
    sent_log.delete();
    busy_len = 3;
    wr = 0; sent = 0; i = 0; guard = 0;
    while ((i < 40 || sent < 40) && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (wr_en) wr++;
      if (tx_send) sent++;
      check("wrap_count", 32'(count), 32'(wr - sent));
      if (i < 40 && count < 3) begin
        wr_data = 8'(8'h40 + i); wr_en = 1'b1; i++;
      end else begin
        wr_en = 1'b0;
      end
    end
    wr_en = 1'b0;
    check("wrap_sent", 32'(sent), 40);
    wait_busy(1'b0, "wrap_idle");
    repeat (4) @(negedge clk);
    check("wrap_log_size", 32'(sent_log.size()), 40);
    for (int k = 0; k < 40 && k < sent_log.size(); k++)
      check("wrap_byte", 32'(sent_log[k]), 32'(8'h40 + k));

    // Flush with 5 queued and one in flight
    sent_log.delete();
    busy_len = 20;
    for (int k = 0; k < 6; k++) begin
      wr_data = 8'(8'h60 + k); wr_en = 1'b1;
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_busy(1'b1, "flush_busy");
    check("flush_pre_count", 32'(count), 5);
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
    @(negedge clk);
    flush = 1'b0; wr_en = 1'b0;
    check("flush_count", 32'(count), 0);
    check("flush_empty", 32'(empty), 1);
    check("flush_full",  32'(full), 0);
`ifdef UART_TX_FIFO_OVF_EN
    check("flush_ovf", 32'(ovf), 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
`endif
    repeat (60) @(negedge clk);
    check("flush_sends", 32'(sent_log.size()), 1);
    check("flush_inflight", 32'(sent_log[0]), 32'h60);
    check("flush_busy_done", 32'(tx_busy), 0);
    wr_data = 8'h77; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    wait_log(2, "post_flush_size");
    if (sent_log.size() >= 2) check("post_flush_byte", 32'(sent_log[1]), 32'h77);
    wait_busy(1'b0, "post_flush_idle");
    repeat (4) @(negedge clk);

    // Reset during WAIT_DONE with bytes still queued
    for (int k = 0; k < 3; k++) begin
      wr_data = 8'(8'h11 * (k + 1)); wr_en = 1'b1;
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_busy(1'b1, "rst_mid_busy");
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_send",  32'(tx_send), 0);
    check("rst_mid_data",  32'(tx_data), 0);
    check("rst_mid_count", 32'(count), 0);
    check("rst_mid_empty", 32'(empty), 1);
    check("rst_mid_full",  32'(full), 0);
    @(negedge clk);
    reset_n = 1'b1;
    sent_log.delete();
    @(negedge clk);
    wr_data = 8'h3C; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    check("rst_after_send", 32'(tx_send), 1);
    check("rst_after_data", 32'(tx_data), 32'h3C);
    repeat (40) @(negedge clk);
    check("rst_after_log", 32'(sent_log.size()), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
